module_keypad_scanner: RTL and testbench
========================================

MODULE_KEYPAD_SCANNER -- requirements
Module: module_keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clock cycles each column is driven; legal range 4..65535.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 8: consecutive stable cycles required to accept a press or release; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port row, input, 4, asynchronous active-high row sense; row[r] high when the key at (r, driven col) is pressed.
REQ-006 SHALL have port col, output, 4, one-hot active-high column drive.
REQ-007 SHALL have port key_code, output, 4, accepted key index = row_idx*4 + col_idx (key 0..15).
REQ-008 SHALL have port key_valid, output, 1, one-cycle pulse on press acceptance.
REQ-009 SHALL have port key_held, output, 1, high from acceptance until release is debounced.

Function
REQ-010 SHALL pass row through a 2-flop synchronizer; all decisions use the synchronized value row_s.
REQ-011 SHALL implement states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-012 In SCAN, col SHALL rotate col0->col1->col2->col3->col0, each held exactly SCAN_DIV cycles; a dwell counter counts 0..SCAN_DIV-1 then wraps.
REQ-013 In SCAN, row_s SHALL be sampled only on the last dwell cycle (count = SCAN_DIV-1); row_s = 0 -> advance column.
REQ-014 Sampled row_s != 0 SHALL latch col_idx and row_idx = lowest set bit of row_s, hold col, clear the debounce counter, enter DEBOUNCE.
REQ-015 In DEBOUNCE, each cycle row_s[row_idx] = 1 increments the counter; on reaching DEBOUNCE_CNT -> PRESSED, key_code updated, key_valid = 1 for that one cycle, key_held = 1.
REQ-016 In DEBOUNCE, row_s[row_idx] = 0 on any cycle SHALL return to SCAN with next column, dwell counter 0, no key_valid.
REQ-017 In PRESSED, col SHALL stay held; row_s[row_idx] = 0 -> RELEASE with counter cleared; other row bits ignored.
REQ-018 In RELEASE, each cycle row_s[row_idx] = 0 increments; reaching DEBOUNCE_CNT -> SCAN, key_held = 0, next column, dwell 0; row_s[row_idx] = 1 -> back to PRESSED, no new key_valid.
REQ-019 key_code SHALL hold its last accepted value until the next acceptance.
REQ-020 Simultaneous keys: only the first found (scan order, then lowest row) SHALL be reported; no further key_valid until its release completes.
REQ-021 Counters SHALL be sized $clog2(max+1) and never wrap during DEBOUNCE/RELEASE (saturate at terminal count).

Reset
REQ-022 rst_n low SHALL immediately force: state SCAN, col = 4'b0001, dwell and debounce counters 0, synchronizer flops 0, key_code = 0, key_valid = 0, key_held = 0.
REQ-023 Reset asserted mid-DEBOUNCE/PRESSED/RELEASE SHALL abort with no key_valid; after deassertion scanning restarts at col0.

Verification
REQ-024 Idle: row = 0 for 32 cycles after reset -> col sequence 0001,0010,0100,1000 repeating every 4 cycles; key_valid never 1.
REQ-025 Press key 9 (row2 responds when col1 = 1) held 40 cycles -> exactly one key_valid, key_code = 9, key_held = 1 while held; release -> key_held falls 8+2 cycles after row returns to 0.
REQ-026 Bounce: row toggles every 3 cycles during DEBOUNCE -> no key_valid, scan resumes next column.
REQ-027 Release glitch: in PRESSED, row low 4 cycles then high -> key_held stays 1, no second key_valid.
REQ-028 Keys 4 and 6 pressed together (row1 for col0 and col2) -> key_code = 4 only; after release of both, key 6 alone is accepted next scan.
REQ-029 rst_n pulsed low during PRESSED -> all outputs 0 and col = 0001 asynchronously; scan restarts after deassertion.

Source files
------------

// File: rtl/module_keypad_scanner.sv
// rtl/module_keypad_scanner.sv - 4x4 matrix keypad scanner with synchronized, debounced press/release
module module_keypad_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [3:0]    r_row_meta;
    logic [3:0]    r_row_s;
    logic [DW-1:0] r_dwell;
    logic [DW-1:0] w_dwell_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [1:0]    r_col_idx;
    logic [1:0]    w_col_idx_next;
    logic [1:0]    r_row_idx;
    logic [1:0]    w_row_idx_next;
    logic [1:0]    w_low_row;
    logic [3:0]    r_key_code;
    logic [3:0]    w_key_code_next;
    logic          r_key_valid;
    logic          w_key_valid_next;
    logic          r_key_held;
    logic          w_key_held_next;
    logic          w_row_bit;

    // Two-flop synchronizer for the asynchronous row sense lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= 4'b0000;
            r_row_s    <= 4'b0000;
        end else begin
            r_row_meta <= row;
            r_row_s    <= r_row_meta;
        end
    end

    always_comb begin
        w_low_row = 2'd0;
        if (r_row_s[0]) begin
            w_low_row = 2'd0;
        end else if (r_row_s[1]) begin
            w_low_row = 2'd1;
        end else if (r_row_s[2]) begin
            w_low_row = 2'd2;
        end else if (r_row_s[3]) begin
            w_low_row = 2'd3;
        end
    end

    assign w_row_bit = r_row_s[r_row_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SCAN;
            r_dwell     <= '0;
            r_cnt       <= '0;
            r_col_idx   <= 2'd0;
            r_row_idx   <= 2'd0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_dwell     <= w_dwell_next;
            r_cnt       <= w_cnt_next;
            r_col_idx   <= w_col_idx_next;
            r_row_idx   <= w_row_idx_next;
            r_key_code  <= w_key_code_next;
            r_key_valid <= w_key_valid_next;
            r_key_held  <= w_key_held_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_dwell_next     = r_dwell;
        w_cnt_next       = r_cnt;
        w_col_idx_next   = r_col_idx;
        w_row_idx_next   = r_row_idx;
        w_key_code_next  = r_key_code;
        w_key_valid_next = 1'b0;
        w_key_held_next  = r_key_held;
        case (r_state)
            ST_SCAN: begin
                // Row is only trusted on the last dwell cycle, once the synchronizer has settled
                if (r_dwell == DWELL_LAST) begin
                    if (r_row_s != 4'b0000) begin
                        w_row_idx_next = w_low_row;
                        w_cnt_next     = '0;
                        w_state_next   = ST_DEBOUNCE;
                    end else begin
                        w_dwell_next   = '0;
                        w_col_idx_next = r_col_idx + 2'd1;
                    end
                end else begin
                    w_dwell_next = r_dwell + DW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (w_row_bit) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_next     = ST_PRESSED;
                        w_key_code_next  = {r_row_idx, r_col_idx};
                        w_key_valid_next = 1'b1;
                        w_key_held_next  = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end else begin
                    w_state_next   = ST_SCAN;
                    w_dwell_next   = '0;
                    w_col_idx_next = r_col_idx + 2'd1;
                end
            end
            ST_PRESSED: begin
                if (!w_row_bit) begin
                    w_state_next = ST_RELEASE;
                    w_cnt_next   = '0;
                end
            end
            ST_RELEASE: begin
                if (!w_row_bit) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_next    = ST_SCAN;
                        w_key_held_next = 1'b0;
                        w_dwell_next    = '0;
                        w_col_idx_next  = r_col_idx + 2'd1;
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end else begin
                    w_state_next = ST_PRESSED;
                end
            end
            default: begin
                w_state_next = ST_SCAN;
            end
        endcase
    end

    assign col       = 4'b0001 << r_col_idx;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_module_keypad_scanner.sv
// tb/tb_module_keypad_scanner.sv - self-checking bench for module_keypad_scanner
module tb_module_keypad_scanner;

    localparam int SD = 4;
    localparam int DC = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys;
    logic        force_en;
    logic [3:0]  force_row;

    int checks;
    int failures;
    int n_valid;

    module_keypad_scanner #(
        .SCAN_DIV     (SD),
        .DEBOUNCE_CNT (DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key connects its column drive to its row line
    always_comb begin
        row = 4'b0000;
        if (force_en) begin
            row = force_row;
        end else begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4+c] && col[c]) row[r] = 1'b1;
                end
            end
        end
    end

    // Behavioural model: mode 0 scan, 1 confirm press, 2 held, 3 confirm release
    typedef struct packed {
        int         mode;
        int         tick;
        int         cnt;
        int         ci;
        int         ri;
        logic [3:0] code;
        logic       valid;
        logic       held;
    } mst_t;

    mst_t       m;
    logic [3:0] m_s1;
    logic [3:0] m_s2;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic mst_t step(input mst_t s, input logic [3:0] rs);
        mst_t n;
        n = s;
        n.valid = 1'b0;
        case (s.mode)
            0: begin
                if ((s.tick % SD) == SD - 1 && rs != 4'b0000) begin
                    n.ci   = s.tick / SD;
                    n.ri   = lowest(rs);
                    n.cnt  = 0;
                    n.mode = 1;
                end else begin
                    n.tick = (s.tick + 1) % (4 * SD);
                end
            end
            1: begin
                if (rs[s.ri]) begin
                    if (s.cnt + 1 == DC) begin
                        n.mode  = 2;
                        n.code  = 4'(s.ri * 4 + s.ci);
                        n.valid = 1'b1;
                        n.held  = 1'b1;
                    end else begin
                        n.cnt = s.cnt + 1;
                    end
                end else begin
                    n.mode = 0;
                    n.tick = ((s.ci + 1) % 4) * SD;
                end
            end
            2: begin
                if (!rs[s.ri]) begin
                    n.mode = 3;
                    n.cnt  = 0;
                end
            end
            default: begin
                if (!rs[s.ri]) begin
                    if (s.cnt + 1 == DC) begin
                        n.mode = 0;
                        n.held = 1'b0;
                        n.tick = ((s.ci + 1) % 4) * SD;
                    end else begin
                        n.cnt = s.cnt + 1;
                    end
                end else begin
                    n.mode = 2;
                end
            end
        endcase
        return n;
    endfunction

    function automatic logic [3:0] exp_col(input mst_t s);
        if (s.mode == 0) return 4'b0001 << (s.tick / SD);
        return 4'b0001 << s.ci;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m    <= '0;
            m_s1 <= 4'b0000;
            m_s2 <= 4'b0000;
        end else begin
            m    <= step(m, m_s2);
            m_s1 <= row;
            m_s2 <= m_s1;
        end
    end

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // One cycle: wait for the falling edge, then compare every output against the model
    task automatic tick();
        @(negedge clk);
        chk4("model_col", col, exp_col(m));
        chk4("model_key_code", key_code, m.code);
        chk4("model_key_valid", {3'b000, key_valid}, {3'b000, m.valid});
        chk4("model_key_held", {3'b000, key_held}, {3'b000, m.held});
        if (key_valid) n_valid++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int i;
        i = 0;
        while (!key_valid && i < budget) begin
            tick();
            i++;
        end
        chki(name, (i < budget) ? 1 : 0, 1);
    endtask

    int n0;
    int h;

    initial begin
        rst_n     = 1'b0;
        keys      = '0;
        force_en  = 1'b0;
        force_row = 4'b0000;
        checks    = 0;
        failures  = 0;
        n_valid   = 0;
        #2;
        chk4("reset_col", col, 4'b0001);
        chk4("reset_key_code", key_code, 4'd0);
        chk4("reset_key_valid", {3'b000, key_valid}, 4'd0);
        chk4("reset_key_held", {3'b000, key_held}, 4'd0);

        // Idle scan
        do_reset();
        for (int k = 0; k < 32; k++) begin
            chk4("idle_col", col, 4'b0001 << ((k / 4) % 4));
            tick();
        end
        chki("idle_no_valid", n_valid, 0);

        // Key 9 held then released
        do_reset();
        n0 = n_valid;
        keys = 16'h0200;
        repeat (40) tick();
        chki("key9_valid_count", n_valid - n0, 1);
        chk4("key9_code", key_code, 4'd9);
        chk4("key9_held", {3'b000, key_held}, 4'd1);
        keys = 16'h0000;
        h = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!key_held) break;
            h++;
        end
        chki("key9_release_latency", h, 10);
        chk4("key9_code_retained", key_code, 4'd9);
        repeat (20) tick();

        // Bouncing contact during press confirmation
        do_reset();
        n0 = n_valid;
        force_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k < 4) force_row = 4'b0001;
            else if (k < 19) force_row = ((((k - 4) / 3) % 2) == 0) ? 4'b0000 : 4'b0001;
            else force_row = 4'b0000;
            if (k == 7) chk4("bounce_next_col", col, 4'b0010);
            tick();
        end
        chki("bounce_no_valid", n_valid - n0, 0);

        // Release glitch on key 8 (row2, col0)
        do_reset();
        n0 = n_valid;
        for (int k = 0; k < 64; k++) begin
            if (k < 20) force_row = 4'b0100;
            else if (k < 24) force_row = 4'b0000;
            else if (k < 40) force_row = 4'b0100;
            else force_row = 4'b0000;
            if (k == 12) begin
                chk4("glitch_accept_valid", {3'b000, key_valid}, 4'd1);
                chk4("glitch_accept_code", key_code, 4'd8);
            end
            if (k >= 20 && k < 40) chk4("glitch_held", {3'b000, key_held}, 4'd1);
            tick();
        end
        chki("glitch_valid_count", n_valid - n0, 1);
        chk4("glitch_released", {3'b000, key_held}, 4'd0);
        force_en = 1'b0;

        // Keys 4 and 6 together, then key 6 alone
        do_reset();
        n0 = n_valid;
        keys = 16'h0050;
        for (int k = 0; k < 64; k++) begin
            if (k == 30) keys = 16'h0000;
            if (k == 44) keys = 16'h0040;
            if (k == 12) chk4("dual_first_code", key_code, 4'd4);
            if (k == 12) chk4("dual_first_valid", {3'b000, key_valid}, 4'd1);
            if (k == 43) chk4("dual_released", {3'b000, key_held}, 4'd0);
            if (k == 43) chk4("dual_code_retained", key_code, 4'd4);
            if (k == 57) chk4("key6_valid", {3'b000, key_valid}, 4'd1);
            if (k == 57) chk4("key6_code", key_code, 4'd6);
            tick();
        end
        chki("dual_valid_count", n_valid - n0, 2);
        keys = 16'h0000;
        repeat (20) tick();

        // Asynchronous reset while a key is held
        do_reset();
        keys = 16'h0200;
        wait_valid("prereset_valid_seen", 40);
        chk4("prereset_code", key_code, 4'd9);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk4("async_reset_col", col, 4'b0001);
        chk4("async_reset_code", key_code, 4'd0);
        chk4("async_reset_valid", {3'b000, key_valid}, 4'd0);
        chk4("async_reset_held", {3'b000, key_held}, 4'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        chk4("restart_col", col, 4'b0001);
        wait_valid("restart_valid_seen", 40);
        chk4("restart_code", key_code, 4'd9);
        keys = 16'h0000;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
